unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Instruction-fetch stage and PC owner. Feeds op/funct to the decoding control unit.
//  Consumes that unit's Branch/Jump/Jal/Jr decisions to redirect the PC.
//  Drives a synchronous instruction memory with 1-cycle read latency.
//  Drops the in-flight fetch on every redirect, inserting one NOP bubble.
// PARAMETERS
//  RESET_PC     32'h0000_0000  byte address fetched first after reset
//  IMEM_ADDR_W  8              word-address width of instruction memory
// PORTS
//  clk          in   1            single clock; all state on rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  stall        in   1            1 = freeze stage (PC, instr reg, valid)
//  branch       in   1            from control unit
//  zero         in   1            ALU zero flag of current instr
//  jump         in   1            from control unit (J)
//  jal          in   1            from control unit (JAL)
//  jr           in   1            from control unit (JR)
//  sign_imm     in   32           sign-extended instr[15:0]
//  reg_a        in   32           rs value (JR target)
//  imem_en      out  1            read enable to instruction memory
//  imem_addr    out  IMEM_ADDR_W  word address = pc_q[IMEM_ADDR_W+1:2]
//  imem_rdata   in   32           read data, valid the cycle after imem_en
//  instr        out  32           current instruction; 32'h0 (NOP) when invalid
//  instr_valid  out  1            instr/instr_pc are real
//  op           out  6            instr[31:26]
//  funct        out  6            instr[5:0]
//  instr_pc     out  32           address of instr
//  pc_plus4     out  32           instr_pc + 4 (JAL link value)
//  fetch_err    out  1            misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc_q=RESET_PC, instr=0, instr_valid=0, instr_pc=0, fetch_err=0, drop flag=0.
//   - imem_en=0 while in reset.
//  Fetch pipeline:
//   - Cycle N: imem_en=1 with address pc_q.
//   - Cycle N+1: instr<=imem_rdata, instr_pc<=pc_q(N), instr_valid=1.
//   - pc_q<=pc_q+4 each unstalled cycle. First valid instr 2nd edge after rst_n release.
//  Redirect (sampled only when instr_valid && !stall):
//   - Priority jr > (jump|jal) > (branch&zero).
//   - jr: reg_a.
//   - jump/jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
//   - branch: pc_plus4 + (sign_imm<<2).
//   - On redirect: pc_q<=target; next cycle instr_valid=0, instr=0 (in-flight word discarded).
//   - Target fetched the cycle after, valid one cycle later.
//   - Penalty: exactly 1 bubble.
//  Stall:
//   - imem_en=0; pc_q, instr, instr_pc, instr_valid held.
//   - Memory data for the pending fetch is refetched on resume (no loss, no duplicate).
//   - stall overrides redirect; the caller holds redirect inputs.
//  Arithmetic:
//   - All PC sums 32-bit, modulo 2^32: 32'hFFFF_FFFC+4 = 0.
//   - imem_addr truncates high bits (wraps memory).
//  Outputs op/funct/pc_plus4: combinational from instr/instr_pc; op=funct=0 while invalid.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   - Redirect target with [1:0]!=0 sets fetch_err=1 (sticky until reset).
//   - Suppresses the redirect; PC freezes; instr_valid stays 0.
//  Not defined: target[1:0] forced to 00, fetch_err tied 0.
// STRUCTURE
//  Shared package mips_pkg:
//   - OP_J=6'b000010, OP_JAL=6'b000011, FUNCT_JR=6'b001000.
//   - INSTR_NOP=32'h0, PC_W=32.
//  Sub-module proximo_pc (combinational): priority target mux + pc_plus4.
//  Top holds pc_q, instruction register, valid/drop flags.
// TESTING
//  1 Reset/sequential: mem[k]=k+1, rst_n rises -> instr_pc 0,4,8 with instr 1,2,3.
//    rst_n low mid-run -> instr_valid=0 and pc_q=0 immediately.
//  2 Taken branch: instr_pc=0x10, branch=zero=1, sign_imm=3 -> one bubble, next valid instr_pc=0x20.
//    Word at 0x14 never valid.
//  3 Jump: instr=32'h0800_0040 at 0x08, jump=1 -> next valid instr_pc=0x100.
//    With jal also: pc_plus4=0x0C during that cycle.
//  4 JR priority: reg_a=0x3C, jr=1 and jump=1 -> next valid instr_pc=0x3C.
//  5 Stall: stall=1 three cycles at instr_pc=0x8 -> outputs constant, imem_en=0.
//    On release -> 0xC, 0x10 follow, no gap or repeat.
//  6 PC_ALIGN_CHECK_EN: jr with reg_a=0x22 -> fetch_err=1, instr_valid stays 0.
//    Without macro -> next instr_pc=0x20.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, PC width and small helpers shared by the fetch stage.
package mips_pkg;

    localparam int          PC_W      = 32;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [5:0]  OP_JAL    = 6'b000011;
    localparam logic [5:0]  FUNCT_JR  = 6'b001000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_sel_e;

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/unidade_busca_proximo_pc.sv
// proximo_pc: combinational redirect-target selection (jr > jump/jal > taken branch) and link value.
module proximo_pc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] instr_pc,
    input  logic [25:0]     jidx,
    input  logic [31:0]     sign_imm,
    input  logic [31:0]     reg_a,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jal,
    input  logic            jr,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] target,
    output logic            take
);

    pc_sel_e sel_s;

    // Priority decode of the control-unit request and the matching target.
    always_comb begin
        pc_plus4 = instr_pc + 32'd4;
        sel_s    = SEL_SEQ;
        if (jr) begin
            sel_s = SEL_JR;
        end else if (jump || jal) begin
            sel_s = SEL_JUMP;
        end else if (branch && zero) begin
            sel_s = SEL_BRANCH;
        end else begin
            sel_s = SEL_SEQ;
        end
        case (sel_s)
            SEL_JR:     target = reg_a;
            SEL_JUMP:   target = {pc_plus4[31:28], jidx, 2'b00};
            SEL_BRANCH: target = pc_plus4 + (sign_imm << 2);
            default:    target = pc_plus4;
        endcase
        take = (sel_s != SEL_SEQ);
    end

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch stage and PC owner; one bubble per redirect.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets raise sticky fetch_err instead of being aligned.
module unidade_busca
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              IMEM_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch,
    input  logic                   zero,
    input  logic                   jump,
    input  logic                   jal,
    input  logic                   jr,
    input  logic [31:0]            sign_imm,
    input  logic [31:0]            reg_a,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [5:0]             op,
    output logic [5:0]             funct,
    output logic [PC_W-1:0]        instr_pc,
    output logic [PC_W-1:0]        pc_plus4,
    output logic                   fetch_err
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_vld_q, fetch_vld_d;
    logic            run_q, run_d;
    logic            hold_q, hold_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic            err_q, err_d;

    logic [PC_W-1:0] target_s, target_al_s;
    logic            take_s, bad_target_s, fetch_s, redirect_s;

    proximo_pc u_proximo_pc (
        .instr_pc (fetch_pc_q),
        .jidx     (instr[25:0]),
        .sign_imm (sign_imm),
        .reg_a    (reg_a),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .jal      (jal),
        .jr       (jr),
        .pc_plus4 (pc_plus4),
        .target   (target_s),
        .take     (take_s)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign bad_target_s = (target_s[1:0] != 2'b00);
    assign target_al_s  = target_s;
`else
    assign bad_target_s = 1'b0;
    assign target_al_s  = align_word(target_s);
`endif

    // run_q keeps the memory idle for the first cycle out of reset.
    assign fetch_s    = run_q && !stall && !err_q;
    assign redirect_s = fetch_vld_q && !stall && !err_q && take_s;

    assign imem_en     = fetch_s;
    assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign instr_valid = fetch_vld_q;
    assign instr_pc    = fetch_pc_q;
    assign fetch_err   = err_q;
    assign op          = instr[31:26];
    assign funct       = instr[5:0];

    // Memory word is live only the cycle after a read; the hold copy covers stalls.
    always_comb begin
        if (!fetch_vld_q) begin
            instr = INSTR_NOP;
        end else if (hold_q) begin
            instr = hold_instr_q;
        end else begin
            instr = imem_rdata;
        end
    end

    // Next-state for PC, fetch tracking, stall hold and error flag.
    always_comb begin
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        fetch_vld_d  = fetch_vld_q;
        run_d        = 1'b1;
        hold_d       = hold_q;
        hold_instr_d = hold_instr_q;
        err_d        = err_q;
        if (stall) begin
            hold_d = 1'b1;
            if (!hold_q) begin
                hold_instr_d = imem_rdata;
            end else begin
                hold_instr_d = hold_instr_q;
            end
        end else begin
            hold_d     = 1'b0;
            fetch_pc_d = pc_q;
            if (redirect_s && bad_target_s) begin
                err_d       = 1'b1;
                fetch_vld_d = 1'b0;
            end else if (redirect_s) begin
                pc_d        = target_al_s;
                fetch_vld_d = 1'b0;
            end else if (fetch_s) begin
                pc_d        = pc_q + 32'd4;
                fetch_vld_d = 1'b1;
            end else begin
                pc_d        = pc_q;
                fetch_vld_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fetch_pc_q   <= 32'h0000_0000;
            fetch_vld_q  <= 1'b0;
            run_q        <= 1'b0;
            hold_q       <= 1'b0;
            hold_instr_q <= 32'h0000_0000;
            err_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_vld_q  <= fetch_vld_d;
            run_q        <= run_d;
            hold_q       <= hold_d;
            hold_instr_q <= hold_instr_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: redirect vector table plus reset, stall and misalignment sequences, with a PC scoreboard.
module tb_unidade_busca;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch, zero, jump, jal, jr;
    logic [31:0] sign_imm, reg_a, imem_rdata, instr, instr_pc, pc_plus4;
    logic        imem_en, instr_valid, fetch_err;
    logic [7:0]  imem_addr;
    logic [5:0]  op, funct;
    logic [31:0] mem [0:255];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] trig;
        logic [31:0] word;
        logic        br, zr, jp, jl, jrr;
        logic [31:0] simm, ra, tgt, p4;
        int          bub;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    unidade_busca #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .jal(jal), .jr(jr), .sign_imm(sign_imm), .reg_a(reg_a),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .op(op), .funct(funct),
        .instr_pc(instr_pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    // Synchronous memory; output is garbage on cycles without a read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each consumed instruction must match the next expected PC.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        #4;
        if (rst_n && instr_valid && !stall && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc", instr_pc, e);
            check("sb_instr", instr, mem[e[9:2]]);
        end
    end

    task automatic do_reset(input logic [31:0] tpc, input logic [31:0] word);
        rst_n = 1'b0; stall = 1'b0;
        {branch, zero, jump, jal, jr} = 5'b00000;
        sign_imm = 32'h0; reg_a = 32'h0;
        exp_q.delete();
        for (int k = 0; k < 256; k++) mem[k] = k + 1;
        mem[tpc[9:2]] = word;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == pc) ok = 1'b1;
        end
        if (!ok) check("wait_pc_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int bub = 0;
        bit fired = 1'b0;
        bit done = 1'b0;
        do_reset(v.trig, v.word);
        for (int p = 0; p <= int'(v.trig); p += 4) exp_q.push_back(p);
        exp_q.push_back(v.tgt);
        exp_q.push_back(v.tgt + 32'd4);
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (fired) begin
                {branch, zero, jump, jal, jr} = 5'b00000;
                if (!instr_valid) begin
                    bub++;
                    check({v.name, "_bubble_instr"}, instr, 32'h0);
                end else begin
                    check({v.name, "_bubbles"}, bub, v.bub);
                    done = 1'b1;
                end
            end else if (instr_valid && instr_pc == v.trig) begin
                check({v.name, "_pc_plus4"}, pc_plus4, v.p4);
                branch = v.br; zero = v.zr; jump = v.jp; jal = v.jl; jr = v.jrr;
                sign_imm = v.simm; reg_a = v.ra;
                fired = 1'b1;
            end
        end
        if (!done) check({v.name, "_timeout"}, 32'd0, 32'd1);
        drain({v.name, "_drain"});
    endtask

    initial begin
        vecs[0] = '{"br_taken", 32'h10, 32'h1000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h0, 32'h20, 32'h14, 1};
        vecs[1] = '{"br_not", 32'h10, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'h0, 32'h14, 32'h14, 0};
        vecs[2] = '{"jump", 32'h08, {OP_J, 26'h40}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 32'h0C, 1};
        vecs[3] = '{"jal", 32'h08, {OP_JAL, 26'h40}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h100, 32'h0C, 1};
        vecs[4] = '{"jr_prio", 32'h08, {OP_J, 26'h40}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h3C, 32'h3C, 32'h0C, 1};
        vecs[5] = '{"br_back", 32'h30, 32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h24, 32'h34, 1};
        vecs[6] = '{"jmp_over_br", 32'h08, {OP_J, 26'h40}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'h0, 32'h100, 32'h0C, 1};
        vecs[7] = '{"jr_wrap", 32'h08, {FUNCT_JR, 26'h0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0C, 1};

        // Reset state and sequential fetch.
        do_reset(32'h0, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_imem_en", imem_en, 1'b0);
        check("rst_fetch_err", fetch_err, 1'b0);
        check("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_valid", instr_valid, 1'b0);
        check("first_edge_en", imem_en, 1'b1);
        check("first_edge_addr", imem_addr, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("seq_valid", instr_valid, 1'b1);
            check("seq_pc", instr_pc, 32'(k * 4));
            check("seq_instr", instr, 32'(k + 1));
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", instr_valid, 1'b0);
        check("midrst_addr", imem_addr, 8'h00);
        check("midrst_en", imem_en, 1'b0);

        // Redirect vectors.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stall for three cycles at 0x8.
        do_reset(32'h0, 32'h1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        wait_pc(32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_instr", instr, 32'd3);
            check("stall_pc", instr_pc, 32'h8);
            check("stall_valid", instr_valid, 1'b1);
            check("stall_en", imem_en, 1'b0);
            @(negedge clk);
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("resume_valid", instr_valid, 1'b1);
        end
        drain("stall_drain");

        // Misaligned JR target.
        do_reset(32'h8, 32'h3);
        wait_pc(32'h8);
        jr = 1'b1; reg_a = 32'h22;
        @(negedge clk);
        jr = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check("mis_err", fetch_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("mis_valid", instr_valid, 1'b0);
            @(negedge clk);
        end
        check("mis_err_sticky", fetch_err, 1'b1);
`else
        check("mis_bubble", instr_valid, 1'b0);
        @(negedge clk);
        check("mis_valid", instr_valid, 1'b1);
        check("mis_pc", instr_pc, 32'h20);
        check("mis_err", fetch_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
